// File: rtl/hex_display_scanner_if.sv
// Load-side inputs and display-side outputs of the hex display scanner, grouped
// so the CPU-facing driver and the scanner share one bundle.
interface hex_display_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic                  enable;
    logic [0:6]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame;

    modport master (
        output load, value, dp_in, blank_lz, enable,
        input  seg, dp, an, frame
    );

    modport slave (
        input  load, value, dp_in, blank_lz, enable,
        output seg, dp, an, frame
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 7-segment hex driver: double-buffered value load, frame-aligned
// transfer, leading-zero blanking and registered, polarity-configurable outputs.
module hex_display_scanner #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    hex_display_scanner_if.slave bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
    logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic                  wrap_q, wrap_d;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  term_cnt;
    logic                  wrap;

    logic [3:0]            nib [DIGITS];
    logic [DIGITS:0]       upper_zero;
    logic [DIGITS-1:0]     blank_vec;
    logic [DIGITS-1:0]     an_onehot;

    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  blank_sel;
    logic [6:0]            seg_lit;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    assign term_cnt = (presc_q == PRESC_LAST);
    assign wrap     = term_cnt && (idx_q == IDX_LAST);

    // A digit is a leading zero when it and every digit above it hold zero.
    assign upper_zero[DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]        = disp_val_q[4*gi +: 4];
            assign upper_zero[gi] = upper_zero[gi+1] && (nib[gi] == 4'h0);
            assign an_onehot[gi]  = (idx_q == IW'(gi));
            if (gi == 0) begin : g_lsd
                assign blank_vec[gi] = 1'b0;
            end else begin : g_upper
                assign blank_vec[gi] = upper_zero[gi];
            end
        end
    endgenerate

    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib_sel   = nib[i];
                dp_sel    = disp_dp_q[i];
                blank_sel = blank_vec[i];
            end
        end
    end

    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        wrap_d       = wrap;

        if (term_cnt) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // Transfer reads the old pending contents; a same-cycle load then refills it.
        if (wrap && pend_valid_q) begin
            disp_val_d   = pend_val_q;
            disp_dp_d    = pend_dp_q;
            pend_valid_d = 1'b0;
        end
        if (bus.load) begin
            pend_val_d   = bus.value;
            pend_dp_d    = bus.dp_in;
            pend_valid_d = 1'b1;
        end
    end

    always_comb begin
        seg_lit = (bus.blank_lz && blank_sel) ? 7'h00 : glyph(nib_sel);
        seg_d   = SEG_OFF;
        dp_d    = DP_OFF;
        an_d    = AN_OFF;
        if (bus.enable) begin
            seg_d = seg_lit ^ {7{SEG_ACTIVE_LOW}};
            dp_d  = dp_sel ^ SEG_ACTIVE_LOW;
            an_d  = an_onehot ^ {DIGITS{AN_ACTIVE_LOW}};
        end
        // Delayed one cycle so the pulse lines up with the registered digit-0 select.
        frame_d = wrap_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            wrap_q       <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            wrap_q       <= wrap_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;

endmodule
